// File: rtl/acid_seq_if.sv
// Bus bundle for the ACID unlock sequencer: host table-load/control lines,
// the CPU-side address/OE requester, and the shared ACID address port.
interface acid_seq_if #(
  parameter int DEPTH = 32
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  // Host loading and control
  logic          PinWrEn;
  logic [7:0]    PinWrData;
  logic          PinClrBuf;
  logic          PinStart;
  logic          PinAbort;
  // CPU requester and ACID return byte
  logic [7:0]    PinCpuA;
  logic          PinCpuOE;
  logic [7:0]    PinSIN;
  // ACID address port and status
  logic [7:0]    PinA;
  logic          PinOE;
  logic          PinBusy;
  logic          PinDone;
  logic [CW-1:0] PinCount;
  logic          PinFull;
  logic [7:0]    PinSnap;

  modport slave (
    input  PinWrEn, PinWrData, PinClrBuf, PinStart, PinAbort,
    input  PinCpuA, PinCpuOE, PinSIN,
    output PinA, PinOE, PinBusy, PinDone, PinCount, PinFull, PinSnap
  );

  modport master (
    output PinWrEn, PinWrData, PinClrBuf, PinStart, PinAbort,
    output PinCpuA, PinCpuOE, PinSIN,
    input  PinA, PinOE, PinBusy, PinDone, PinCount, PinFull, PinSnap
  );
endinterface

// File: rtl/acid_seq.sv
// ACID unlock sequencer / address-port arbiter.
// Replays a host-loaded byte table into the ACID address/OE port as timed
// strobes, then snapshots the ACID output byte. When idle, the CPU requester
// drives the ACID port directly. Everything runs on the falling clock edge,
// the same edge the ACID itself uses.
module acid_seq #(
  parameter int DEPTH = 32,
  parameter int GAP   = 3
) (
  input  logic      PinCLK,
  input  logic      PinCCLR,
  acid_seq_if.slave bus
);
  localparam int            AW      = $clog2(DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  // Gap counter load value; unused when GAP is 0 (strobes run back to back).
  localparam logic [3:0]    GAP_LD  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_GAP,
    S_FINISH
  } state_t;

  state_t        state_q;
  logic [7:0]    table_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [3:0]    gap_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [7:0]    a_q;
  logic          oe_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    snap_q;

  logic          idle;
  logic          full;
  logic          last_entry;
  logic          clr_d;
  logic          wr_d;
  logic          start_d;
  logic [AW-1:0] rd_next;

  assign idle       = (state_q == S_IDLE);
  assign full       = (count_q == DEPTH_C);
  assign last_entry = ({1'b0, rd_q} == (count_q - CW'(1)));
  assign rd_next    = rd_q + AW'(1);

  // Host commands only act while idle; clear beats a same-edge write,
  // abort beats a same-edge start.
  assign clr_d   = idle && bus.PinClrBuf;
  assign wr_d    = idle && bus.PinWrEn && !full && !bus.PinClrBuf;
  assign start_d = idle && bus.PinStart && !bus.PinAbort;

  // Entry count: cleared, incremented on an accepted write, else held.
  always_comb begin
    count_d = count_q;
    if (clr_d) begin
      count_d = '0;
    end else if (wr_d) begin
      count_d = count_q + CW'(1);
    end
  end

  // Sequence table storage; deliberately not reset so contents survive reset.
  always_ff @(negedge PinCLK) begin
    if (wr_d) begin
      table_q[count_q[AW-1:0]] <= bus.PinWrData;
    end
  end

  // Playback FSM with registered port outputs, busy/done flags, count and snapshot.
  always_ff @(negedge PinCLK or negedge PinCCLR) begin
    if (!PinCCLR) begin
      state_q <= S_IDLE;
      rd_q    <= '0;
      gap_q   <= '0;
      count_q <= '0;
      a_q     <= 8'hFF;
      oe_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      snap_q  <= 8'h00;
    end else begin
      done_q  <= 1'b0;
      count_q <= count_d;
      if (!idle && bus.PinAbort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        oe_q    <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_d) begin
              busy_q <= 1'b1;
              rd_q   <= '0;
              if (count_q != '0) begin
                state_q <= S_STROBE;
                a_q     <= table_q[0];
                oe_q    <= 1'b0;
              end else begin
                // Empty table: no strobes, just the finishing snapshot.
                state_q <= S_FINISH;
                oe_q    <= 1'b1;
              end
            end
          end
          S_STROBE: begin
            if (last_entry) begin
              state_q <= S_FINISH;
              oe_q    <= 1'b1;
            end else if (GAP > 0) begin
              state_q <= S_GAP;
              oe_q    <= 1'b1;
              gap_q   <= GAP_LD;
              rd_q    <= rd_next;
            end else begin
              state_q <= S_STROBE;
              a_q     <= table_q[rd_next];
              oe_q    <= 1'b0;
              rd_q    <= rd_next;
            end
          end
          S_GAP: begin
            if (gap_q == 4'd0) begin
              state_q <= S_STROBE;
              a_q     <= table_q[rd_q];
              oe_q    <= 1'b0;
            end else begin
              gap_q <= gap_q - 4'd1;
            end
          end
          S_FINISH: begin
            state_q <= S_IDLE;
            snap_q  <= bus.PinSIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            oe_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  // Shared ACID port: sequencer owns it while busy, CPU otherwise.
  assign bus.PinA     = busy_q ? a_q  : bus.PinCpuA;
  assign bus.PinOE    = busy_q ? oe_q : bus.PinCpuOE;
  assign bus.PinBusy  = busy_q;
  assign bus.PinDone  = done_q;
  assign bus.PinCount = count_q;
  assign bus.PinFull  = full;
  assign bus.PinSnap  = snap_q;
endmodule

// File: tb/tb_acid_seq.sv
// Self-checking bench for acid_seq: one instance with GAP=3/DEPTH=32 and one
// with GAP=0/DEPTH=4. Expected strobes are queued when playback is started and
// popped as the DUT issues OE-low cycles. Inputs are driven and outputs are
// sampled on the rising edge, away from the falling active edge.
module tb_acid_seq;
  logic clk = 1'b1;
  logic rst_a_n;
  logic rst_b_n;
  always #5 clk = ~clk;

  acid_seq_if #(.DEPTH(32)) ifa ();
  acid_seq_if #(.DEPTH(4))  ifb ();

  acid_seq #(.DEPTH(32), .GAP(3)) dut_a (.PinCLK(clk), .PinCCLR(rst_a_n), .bus(ifa));
  acid_seq #(.DEPTH(4),  .GAP(0)) dut_b (.PinCLK(clk), .PinCCLR(rst_b_n), .bus(ifb));

  int vecs = 0;
  int errs = 0;
  int         exp_cyc_q[$];
  logic [7:0] exp_addr_q[$];
  logic [7:0] last_snap;

  task automatic write_a(input logic [7:0] d);
    ifa.PinWrEn   = 1'b1;
    ifa.PinWrData = d;
    @(posedge clk);
    ifa.PinWrEn   = 1'b0;
  endtask

  // Start dut_a from a rising edge and watch n_cyc cycles, comparing strobes
  // against the scoreboard. Busy is expected through cycle busy_last.
  task automatic play_a(input int n_cyc, input int busy_last, input int abort_at,
                        output int done_cnt, output int done_cyc, output logic [7:0] snap_e);
    int         c;
    logic [7:0] a;
    done_cnt = 0;
    done_cyc = -1;
    snap_e   = 8'h00;
    ifa.PinStart = 1'b1;
    for (int k = 1; k <= n_cyc; k++) begin
      @(posedge clk);
      ifa.PinStart = 1'b0;
      ifa.PinAbort = (k == abort_at);
      vecs++;
      if (ifa.PinBusy !== (k <= busy_last)) begin
        errs++;
        $display("FAIL busy_cyc%0d: got %b want %b", k, ifa.PinBusy, (k <= busy_last));
      end
      if (ifa.PinBusy === 1'b1 && ifa.PinOE === 1'b0) begin
        vecs++;
        if (exp_cyc_q.size() == 0) begin
          errs++;
          $display("FAIL unexpected_strobe_cyc%0d: got A=%h want no strobe", k, ifa.PinA);
        end else begin
          c = exp_cyc_q.pop_front();
          a = exp_addr_q.pop_front();
          if (k !== c || ifa.PinA !== a) begin
            errs++;
            $display("FAIL strobe: got cyc %0d A=%h want cyc %0d A=%h", k, ifa.PinA, c, a);
          end
        end
      end
      if (ifa.PinBusy === 1'b0) begin
        vecs++;
        if (ifa.PinA !== ifa.PinCpuA || ifa.PinOE !== ifa.PinCpuOE) begin
          errs++;
          $display("FAIL passthru_cyc%0d: got A=%h OE=%b want A=%h OE=%b", k,
                   ifa.PinA, ifa.PinOE, ifa.PinCpuA, ifa.PinCpuOE);
        end
      end
      if (ifa.PinDone === 1'b1) begin
        done_cnt++;
        done_cyc = k;
      end
      ifa.PinSIN = 8'hA0 + 8'(k);
      if (k == busy_last) snap_e = ifa.PinSIN;
    end
    ifa.PinAbort = 1'b0;
    vecs++;
    if (exp_cyc_q.size() != 0) begin
      errs++;
      $display("FAIL missing_strobes: got %0d left want 0", exp_cyc_q.size());
    end
    exp_cyc_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    ifa.PinWrEn = 0; ifa.PinWrData = 0; ifa.PinClrBuf = 0; ifa.PinStart = 0; ifa.PinAbort = 0;
    ifa.PinSIN = 8'h00; ifa.PinCpuA = 8'h5A; ifa.PinCpuOE = 1'b0;
    ifb.PinWrEn = 0; ifb.PinWrData = 0; ifb.PinClrBuf = 0; ifb.PinStart = 0; ifb.PinAbort = 0;
    ifb.PinSIN = 8'h00; ifb.PinCpuA = 8'hA5; ifb.PinCpuOE = 1'b1;
    #2;
    vecs++; if (ifa.PinA !== 8'h5A) begin errs++; $display("FAIL reset_pina: got %h want 5a", ifa.PinA); end
    vecs++; if (ifa.PinOE !== 1'b0) begin errs++; $display("FAIL reset_pinoe: got %b want 0", ifa.PinOE); end
    vecs++; if (ifa.PinBusy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", ifa.PinBusy); end
    vecs++; if (ifa.PinDone !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", ifa.PinDone); end
    vecs++; if (ifa.PinCount !== 6'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", ifa.PinCount); end
    vecs++; if (ifa.PinFull !== 1'b0) begin errs++; $display("FAIL reset_full: got %b want 0", ifa.PinFull); end
    vecs++; if (ifa.PinSnap !== 8'h00) begin errs++; $display("FAIL reset_snap: got %h want 00", ifa.PinSnap); end
    vecs++; if (ifb.PinA !== 8'hA5 || ifb.PinOE !== 1'b1) begin
      errs++; $display("FAIL reset_b_passthru: got %h/%b want a5/1", ifb.PinA, ifb.PinOE);
    end
    @(posedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_load_play();
    int dc, dy;
    logic [7:0] se;
    ifa.PinCpuA = 8'hC3;
    ifa.PinCpuOE = 1'b0;
    write_a(8'h11); write_a(8'h22); write_a(8'h33);
    vecs++; if (ifa.PinCount !== 6'd3) begin errs++; $display("FAIL load_count: got %0d want 3", ifa.PinCount); end
    exp_cyc_q.push_back(1); exp_addr_q.push_back(8'h11);
    exp_cyc_q.push_back(5); exp_addr_q.push_back(8'h22);
    exp_cyc_q.push_back(9); exp_addr_q.push_back(8'h33);
    play_a(14, 10, 0, dc, dy, se);
    vecs++; if (dc !== 1) begin errs++; $display("FAIL play_done_count: got %0d want 1", dc); end
    vecs++; if (dy !== 11) begin errs++; $display("FAIL play_done_cycle: got %0d want 11", dy); end
    vecs++; if (ifa.PinSnap !== se) begin errs++; $display("FAIL play_snap: got %h want %h", ifa.PinSnap, se); end
  endtask

  task automatic test_full();
    ifa.PinClrBuf = 1'b1;
    @(posedge clk);
    ifa.PinClrBuf = 1'b0;
    for (int i = 0; i < 34; i++) write_a(8'(i));
    vecs++; if (ifa.PinCount !== 6'd32) begin errs++; $display("FAIL full_count: got %0d want 32", ifa.PinCount); end
    vecs++; if (ifa.PinFull !== 1'b1) begin errs++; $display("FAIL full_flag: got %b want 1", ifa.PinFull); end
    ifa.PinClrBuf = 1'b1;
    ifa.PinWrEn   = 1'b1;
    @(posedge clk);
    ifa.PinClrBuf = 1'b0;
    ifa.PinWrEn   = 1'b0;
    vecs++; if (ifa.PinCount !== 6'd0) begin errs++; $display("FAIL clr_count: got %0d want 0", ifa.PinCount); end
    vecs++; if (ifa.PinFull !== 1'b0) begin errs++; $display("FAIL clr_full: got %b want 0", ifa.PinFull); end
  endtask

  task automatic test_empty_start();
    int dc, dy;
    logic [7:0] se;
    play_a(4, 1, 0, dc, dy, se);
    vecs++; if (dc !== 1) begin errs++; $display("FAIL empty_done_count: got %0d want 1", dc); end
    vecs++; if (dy !== 2) begin errs++; $display("FAIL empty_done_cycle: got %0d want 2", dy); end
    vecs++; if (ifa.PinSnap !== se) begin errs++; $display("FAIL empty_snap: got %h want %h", ifa.PinSnap, se); end
    last_snap = se;
  endtask

  task automatic test_abort();
    int dc, dy;
    logic [7:0] se;
    write_a(8'h44); write_a(8'h55); write_a(8'h66);
    exp_cyc_q.push_back(1); exp_addr_q.push_back(8'h44);
    exp_cyc_q.push_back(5); exp_addr_q.push_back(8'h55);
    play_a(12, 6, 6, dc, dy, se);
    vecs++; if (dc !== 0) begin errs++; $display("FAIL abort_done: got %0d want 0", dc); end
    vecs++; if (ifa.PinSnap !== last_snap) begin errs++; $display("FAIL abort_snap: got %h want %h", ifa.PinSnap, last_snap); end
    vecs++; if (ifa.PinCount !== 6'd3) begin errs++; $display("FAIL abort_count: got %0d want 3", ifa.PinCount); end
    exp_cyc_q.push_back(1); exp_addr_q.push_back(8'h44);
    exp_cyc_q.push_back(5); exp_addr_q.push_back(8'h55);
    exp_cyc_q.push_back(9); exp_addr_q.push_back(8'h66);
    play_a(14, 10, 0, dc, dy, se);
    vecs++; if (dc !== 1 || dy !== 11) begin errs++; $display("FAIL replay_done: got %0d@%0d want 1@11", dc, dy); end
    vecs++; if (ifa.PinSnap !== se) begin errs++; $display("FAIL replay_snap: got %h want %h", ifa.PinSnap, se); end
  endtask

  task automatic test_reset_mid_strobe();
    ifa.PinCpuA  = 8'h3C;
    ifa.PinCpuOE = 1'b1;
    ifa.PinStart = 1'b1;
    @(posedge clk);
    ifa.PinStart = 1'b0;
    vecs++; if (ifa.PinOE !== 1'b0 || ifa.PinA !== 8'h44) begin
      errs++; $display("FAIL midrst_strobe: got %h/%b want 44/0", ifa.PinA, ifa.PinOE);
    end
    #1 rst_a_n = 1'b0;
    #1;
    vecs++; if (ifa.PinOE !== 1'b1 || ifa.PinA !== 8'h3C) begin
      errs++; $display("FAIL midrst_passthru: got %h/%b want 3c/1", ifa.PinA, ifa.PinOE);
    end
    vecs++; if (ifa.PinBusy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b want 0", ifa.PinBusy); end
    vecs++; if (ifa.PinCount !== 6'd0) begin errs++; $display("FAIL midrst_count: got %0d want 0", ifa.PinCount); end
    @(posedge clk);
    rst_a_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      vecs++; if (ifa.PinDone !== 1'b0) begin errs++; $display("FAIL midrst_done: got %b want 0", ifa.PinDone); end
    end
  endtask

  task automatic test_back_to_back();
    int         c, dc, dy;
    logic [7:0] a, se;
    for (int i = 0; i < 4; i++) begin
      ifb.PinWrEn   = 1'b1;
      ifb.PinWrData = 8'h81 + 8'(i);
      @(posedge clk);
    end
    ifb.PinWrEn = 1'b0;
    vecs++; if (ifb.PinCount !== 3'd4 || ifb.PinFull !== 1'b1) begin
      errs++; $display("FAIL b_full: got %0d/%b want 4/1", ifb.PinCount, ifb.PinFull);
    end
    for (int i = 0; i < 4; i++) begin
      exp_cyc_q.push_back(i + 1);
      exp_addr_q.push_back(8'h81 + 8'(i));
    end
    dc = 0; dy = -1; se = 8'h00;
    ifb.PinStart = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      ifb.PinStart = 1'b0;
      vecs++;
      if (ifb.PinBusy !== (k <= 5)) begin
        errs++; $display("FAIL b_busy_cyc%0d: got %b want %b", k, ifb.PinBusy, (k <= 5));
      end
      if (ifb.PinBusy === 1'b1 && ifb.PinOE === 1'b0) begin
        vecs++;
        if (exp_cyc_q.size() == 0) begin
          errs++; $display("FAIL b_unexpected_strobe_cyc%0d: got A=%h want none", k, ifb.PinA);
        end else begin
          c = exp_cyc_q.pop_front();
          a = exp_addr_q.pop_front();
          if (k !== c || ifb.PinA !== a) begin
            errs++; $display("FAIL b_strobe: got cyc %0d A=%h want cyc %0d A=%h", k, ifb.PinA, c, a);
          end
        end
      end
      if (ifb.PinDone === 1'b1) begin dc++; dy = k; end
      ifb.PinSIN = 8'h50 + 8'(k);
      if (k == 5) se = ifb.PinSIN;
    end
    vecs++; if (exp_cyc_q.size() != 0) begin errs++; $display("FAIL b_missing_strobes: got %0d want 0", exp_cyc_q.size()); end
    exp_cyc_q.delete();
    exp_addr_q.delete();
    vecs++; if (dc !== 1 || dy !== 6) begin errs++; $display("FAIL b_done: got %0d@%0d want 1@6", dc, dy); end
    vecs++; if (ifb.PinSnap !== se) begin errs++; $display("FAIL b_snap: got %h want %h", ifb.PinSnap, se); end
  endtask

  initial begin
    test_reset();
    test_load_play();
    test_full();
    test_empty_start();
    test_abort();
    test_reset_mid_strobe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/acid_seq.md
# acid_seq

Unlock sequencer and address-port arbiter for the ACID lockout emulation. Holds a host-loaded table of up to DEPTH address bytes and, on command, replays it into the ACID's 8-bit address and OE inputs as timed strobes. It then captures the ACID's PinSIN byte as a status snapshot. When idle, it passes the CPU-side address/OE requester straight through to the ACID, so the two share one address port.

## Interface
- DEPTH, 32: sequence buffer entries; power of two, 2..256.
- GAP, 3: idle cycles with OE high between consecutive strobes; 0..15.

- PinCLK  in  1  clock; all state changes on the falling edge (same edge as ACID).
- PinCCLR  in  1  reset, asynchronous, active-low.
- PinWrEn  in  1  load strobe; writes PinWrData at the write pointer.
- PinWrData  in  8  table byte.
- PinClrBuf  in  1  sets count to 0. Table contents are kept.
- PinStart  in  1  begin playback from entry 0.
- PinAbort  in  1  stop playback.
- PinCpuA  in  8  CPU requester address.
- PinCpuOE  in  1  CPU requester OE, active-low.
- PinSIN  in  8  ACID output byte.
- PinA  out  8  to ACID address.
- PinOE  out  1  to ACID OE, active-low.
- PinBusy  out  1  playback in progress. CPU requester is locked out while high.
- PinDone  out  1  one-cycle pulse on normal completion.
- PinCount  out  log2(DEPTH)+1  entries loaded.
- PinFull  out  1  PinCount == DEPTH.
- PinSnap  out  8  PinSIN captured at completion.

## Operation
- States: IDLE, STROBE, GAP, FINISH.
- IDLE
  - PinA = PinCpuA and PinOE = PinCpuOE (combinational mux, select = registered PinBusy).
  - PinWrEn with !PinFull: writes table[count], count+1.
  - PinWrEn while full is ignored.
  - PinClrBuf: count=0. It wins over a same-edge PinWrEn.
  - PinStart with count>0: go to STROBE, rd=0, PinBusy=1.
  - PinStart with count=0: PinDone pulses on the next edge, PinSnap is loaded from PinSIN, no strobes are issued.
- STROBE
  - Lasts 1 cycle. Registered PinA=table[rd], PinOE=0.
  - If rd==count-1, go to FINISH.
  - Otherwise go to GAP with rd+1 (GAP>0), or to STROBE with rd+1 (GAP=0).
- GAP
  - Lasts GAP cycles. PinA holds the last byte, PinOE=1. Then go to STROBE.
- FINISH
  - Lasts 1 cycle, PinOE=1.
  - On exit: PinSnap<=PinSIN, PinDone=1 for one cycle, PinBusy=0, go to IDLE.
- While PinBusy:
  - PinWrEn, PinClrBuf and PinStart are ignored.
  - CPU inputs are ignored (not queued).
- PinAbort, in any non-IDLE state: next edge goes to IDLE with PinBusy=0 and no PinDone. PinSnap, count and table are unchanged. PinAbort wins over a same-edge PinStart.
- Table contents survive playback, so a later PinStart replays the identical sequence.
- Arithmetic:
  - rd and the write pointer are log2(DEPTH) bits.
  - count is one bit wider and never wraps; it saturates at DEPTH via the full check.

## Timing
- Reset (PinCCLR low, asynchronous):
  - State=IDLE, PinBusy=0, PinDone=0, PinCount=0, PinFull=0, PinSnap=8'h00.
  - Sequencer PinA register=8'hFF, OE register=1.
  - PinA/PinOE follow the CPU inputs immediately.
  - The table is not cleared.
- Reset mid-playback: behaves exactly as above; no PinDone.
- PinStart is sampled at edge t0; the first strobe is driven during t0..t0+1. The ACID consumes each strobe at the edge ending STROBE.
- With N entries, PinDone is high after edge t0 + N + (N-1)·GAP + 1, for exactly one cycle.
- PinBusy rises after t0 and falls together with PinDone rising.
- PinCount/PinFull update at the edge that samples PinWrEn or PinClrBuf.

## Test plan
- Reset, then drive PinCpuA=8'h5A, PinCpuOE=0 → PinA=8'h5A, PinOE=0 combinationally; PinBusy=0, PinSnap=8'h00.
- Load 8'h11, 8'h22, 8'h33 with GAP=3, then PinStart → OE low on cycles 1, 5, 9 with PinA 11/22/33; PinDone exactly after edge t0+10; PinSnap equals PinSIN sampled at that edge.
- Write DEPTH+2 bytes → PinCount=DEPTH and PinFull=1; the extra writes are ignored. PinClrBuf with a same-edge PinWrEn → PinCount=0.
- PinStart with count=0 → PinDone after t0+1, no OE-low cycle.
- PinAbort during the second GAP → PinBusy=0 next edge, no PinDone, CPU pass-through restored. A later PinStart replays from entry 0.
- Assert PinCCLR low mid-STROBE → PinOE follows PinCpuOE immediately, PinCount=0. Then reload and play with GAP=0 → back-to-back OE-low cycles.
